// File: rtl/clk_edge_gen.sv
// Multi-channel divided-clock generator with edge strobes, delayed strobes and edge counters.
// All channels launch together on start and return to idle together on stop.
module clk_edge_gen #(
  parameter int unsigned NCH   = 4,
  parameter int unsigned DIV_W = 8,
  parameter int unsigned DLY_W = 4,
  parameter int unsigned CNT_W = 16,
  localparam int unsigned CH_W = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cfg_valid,
  output logic                 cfg_ready,
  input  logic [CH_W-1:0]      cfg_ch,
  input  logic [DIV_W-1:0]     cfg_half,
  input  logic [DIV_W-1:0]     cfg_phase,
  input  logic [DLY_W-1:0]     cfg_dly,
  input  logic [1:0]           cfg_mode,
  input  logic                 start,
  input  logic                 stop,
  output logic [NCH-1:0]       gclk,
  output logic [NCH-1:0]       pos_stb,
  output logic [NCH-1:0]       neg_stb,
  output logic [NCH-1:0]       dly_stb,
  output logic [NCH-1:0]       dly_ovf,
  output logic [NCH*CNT_W-1:0] edge_cnt,
  output logic                 busy
);

  typedef enum logic [1:0] {StIdle, StPhase, StRun} state_e;

  logic [NCH-1:0] active;
  logic           start_go;
  logic           cfg_we;

  assign busy      = |active;
  assign cfg_ready = ~busy;
  assign start_go  = start & ~stop & ~busy;
  assign cfg_we    = cfg_valid & ~busy;

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    state_e           state_q;
    logic [DIV_W-1:0] half_q, phase_q, cnt_q, half_eff;
    logic [DLY_W-1:0] dly_q, dcnt_q;
    logic [1:0]       mode_q;
    logic             gclk_q, pos_q, neg_q, dstb_q, ovf_q, pend_q;
    logic [CNT_W-1:0] ecnt_q;
    logic             ev_pos, ev_neg, ev_sel, dly_due, arm;

    // ev_pos/ev_neg: an edge strobe will be shown in the next cycle.
    always_comb begin
      half_eff = (half_q == '0) ? DIV_W'(1) : half_q;
      ev_pos   = 1'b0;
      ev_neg   = 1'b0;
      if (!stop) begin
        case (state_q)
          StIdle:  ev_pos = start_go && (mode_q != 2'b00) && (phase_q == '0);
          StPhase: ev_pos = (cnt_q == '0);
          StRun: begin
            if (cnt_q == '0) begin
              ev_pos = ~gclk_q;
              ev_neg = gclk_q;
            end
          end
          default: ;
        endcase
      end
      ev_sel  = (ev_pos & mode_q[0]) | (ev_neg & mode_q[1]);
      dly_due = !stop && pend_q && (dcnt_q == DLY_W'(1));
      arm     = ev_sel && (dly_q != '0);
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        state_q <= StIdle;
        half_q  <= DIV_W'(1);
        phase_q <= '0;
        dly_q   <= '0;
        mode_q  <= 2'b00;
        cnt_q   <= '0;
        dcnt_q  <= '0;
        gclk_q  <= 1'b0;
        pos_q   <= 1'b0;
        neg_q   <= 1'b0;
        dstb_q  <= 1'b0;
        ovf_q   <= 1'b0;
        pend_q  <= 1'b0;
        ecnt_q  <= '0;
      end else begin
        pos_q  <= ev_pos;
        neg_q  <= ev_neg;
        dstb_q <= dly_due | (ev_sel && (dly_q == '0));

        if (cfg_we && (cfg_ch == CH_W'(i))) begin
          half_q  <= cfg_half;
          phase_q <= cfg_phase;
          dly_q   <= cfg_dly;
          mode_q  <= cfg_mode;
        end

        if (stop) begin
          state_q <= StIdle;
          gclk_q  <= 1'b0;
          pend_q  <= 1'b0;
        end else begin
          // cnt_q holds remaining phase cycles in StPhase, remaining level cycles in StRun.
          case (state_q)
            StIdle: begin
              if (start_go && (mode_q != 2'b00)) begin
                if (phase_q == '0) begin
                  state_q <= StRun;
                  gclk_q  <= 1'b1;
                  cnt_q   <= half_eff - DIV_W'(1);
                end else begin
                  state_q <= StPhase;
                  cnt_q   <= phase_q - DIV_W'(1);
                end
              end
            end
            StPhase: begin
              if (cnt_q == '0) begin
                state_q <= StRun;
                gclk_q  <= 1'b1;
                cnt_q   <= half_eff - DIV_W'(1);
              end else begin
                cnt_q <= cnt_q - DIV_W'(1);
              end
            end
            StRun: begin
              if (cnt_q == '0) begin
                gclk_q <= ~gclk_q;
                cnt_q  <= half_eff - DIV_W'(1);
              end else begin
                cnt_q <= cnt_q - DIV_W'(1);
              end
            end
            default: state_q <= StIdle;
          endcase

          if (arm) begin
            pend_q <= 1'b1;
            dcnt_q <= dly_q;
          end else if (dly_due) begin
            pend_q <= 1'b0;
          end else if (pend_q) begin
            dcnt_q <= dcnt_q - DLY_W'(1);
          end
        end

        // A delay firing in the same cycle as the new edge is delivered, not overrun.
        if (start_go) begin
          ovf_q <= 1'b0;
        end else if (arm && pend_q && !dly_due) begin
          ovf_q <= 1'b1;
        end

        if (start_go) begin
          ecnt_q <= ev_pos ? CNT_W'(1) : '0;
        end else if ((ev_pos | ev_neg) && (ecnt_q != '1)) begin
          ecnt_q <= ecnt_q + CNT_W'(1);
        end
      end
    end

    assign active[i]                   = (state_q != StIdle);
    assign gclk[i]                     = gclk_q;
    assign pos_stb[i]                  = pos_q;
    assign neg_stb[i]                  = neg_q;
    assign dly_stb[i]                  = dstb_q;
    assign dly_ovf[i]                  = ovf_q;
    assign edge_cnt[i*CNT_W +: CNT_W]  = ecnt_q;
  end

endmodule

// File: tb/tb_clk_edge_gen.sv
// Randomized bench for clk_edge_gen against a cycle-indexed arithmetic model of each channel.
module tb_clk_edge_gen;
  localparam int NCH   = 4;
  localparam int DIV_W = 8;
  localparam int DLY_W = 4;
  localparam int CNT_W = 16;
  localparam int CH_W  = 2;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 cfg_valid, cfg_ready, start, stop, busy;
  logic [CH_W-1:0]      cfg_ch;
  logic [DIV_W-1:0]     cfg_half, cfg_phase;
  logic [DLY_W-1:0]     cfg_dly;
  logic [1:0]           cfg_mode;
  logic [NCH-1:0]       gclk, pos_stb, neg_stb, dly_stb, dly_ovf;
  logic [NCH*CNT_W-1:0] edge_cnt;

  clk_edge_gen #(.NCH(NCH), .DIV_W(DIV_W), .DLY_W(DLY_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_ch(cfg_ch),
    .cfg_half(cfg_half), .cfg_phase(cfg_phase), .cfg_dly(cfg_dly), .cfg_mode(cfg_mode),
    .start(start), .stop(stop), .gclk(gclk), .pos_stb(pos_stb), .neg_stb(neg_stb),
    .dly_stb(dly_stb), .dly_ovf(dly_ovf), .edge_cnt(edge_cnt), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Model: config, launch snapshot, start cycle, pending-delay due cycle per channel.
  int c_half[NCH], c_phase[NCH], c_dly[NCH], c_mode[NCH];
  int r_half[NCH], r_phase[NCH], r_dly[NCH], r_mode[NCH];
  int m_s[NCH], due[NCH], ecnt[NCH];
  bit m_run[NCH], m_ovf[NCH];
  int cyc;
  logic [NCH-1:0] e_gclk, e_pos, e_neg, e_dly, e_ovf;
  logic [63:0]    e_cnt;
  logic           e_busy;

  function automatic void model_outputs();
    e_busy = 1'b0;
    e_cnt  = '0;
    for (int i = 0; i < NCH; i++) begin
      e_busy               |= m_run[i];
      e_ovf[i]              = m_ovf[i];
      e_cnt[i*CNT_W +: CNT_W] = CNT_W'(ecnt[i]);
    end
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < NCH; i++) begin
      c_half[i] = 1; c_phase[i] = 0; c_dly[i] = 0; c_mode[i] = 0;
      m_run[i] = 0; m_ovf[i] = 0; due[i] = -1; ecnt[i] = 0;
    end
    cyc = 0;
    e_gclk = '0; e_pos = '0; e_neg = '0; e_dly = '0;
    model_outputs();
  endfunction

  // Advance the model by one clock edge using the inputs sampled at that edge.
  function automatic void model_edge();
    bit busy_prev = 0;
    int h, k, ph;
    bit p, n, sel;
    for (int i = 0; i < NCH; i++) busy_prev |= m_run[i];
    cyc++;
    if (stop) begin
      for (int i = 0; i < NCH; i++) begin m_run[i] = 0; due[i] = -1; end
    end else if (start && !busy_prev) begin
      for (int i = 0; i < NCH; i++) begin
        ecnt[i] = 0; m_ovf[i] = 0; due[i] = -1;
        if (c_mode[i] != 0) begin
          m_run[i] = 1; m_s[i] = cyc;
          r_half[i] = c_half[i]; r_phase[i] = c_phase[i];
          r_dly[i] = c_dly[i]; r_mode[i] = c_mode[i];
        end
      end
    end
    if (cfg_valid && !busy_prev && int'(cfg_ch) < NCH) begin
      c_half[cfg_ch] = int'(cfg_half); c_phase[cfg_ch] = int'(cfg_phase);
      c_dly[cfg_ch] = int'(cfg_dly);   c_mode[cfg_ch] = int'(cfg_mode);
    end
    e_gclk = '0; e_pos = '0; e_neg = '0; e_dly = '0;
    for (int i = 0; i < NCH; i++) begin
      if (m_run[i]) begin
        h  = (r_half[i] == 0) ? 1 : r_half[i];
        k  = cyc - m_s[i] - r_phase[i];
        ph = (k >= 0) ? (k % (2 * h)) : -1;
        p  = (ph == 0);
        n  = (ph == h);
        e_gclk[i] = (k >= 0) && (ph < h);
        e_pos[i]  = p;
        e_neg[i]  = n;
        if ((p || n) && ecnt[i] < 65535) ecnt[i]++;
        if (due[i] == cyc) begin e_dly[i] = 1'b1; due[i] = -1; end
        sel = (p && r_mode[i][0]) || (n && r_mode[i][1]);
        if (sel) begin
          if (r_dly[i] == 0) e_dly[i] = 1'b1;
          else begin
            if (due[i] > cyc) m_ovf[i] = 1;
            due[i] = cyc + r_dly[i];
          end
        end
      end
    end
    model_outputs();
  endfunction

  task automatic check_all();
    check("gclk", 64'(gclk), 64'(e_gclk));
    check("pos_stb", 64'(pos_stb), 64'(e_pos));
    check("neg_stb", 64'(neg_stb), 64'(e_neg));
    check("dly_stb", 64'(dly_stb), 64'(e_dly));
    check("dly_ovf", 64'(dly_ovf), 64'(e_ovf));
    check("edge_cnt", 64'(edge_cnt), e_cnt);
    check("busy", 64'(busy), 64'(e_busy));
    check("cfg_ready", 64'(cfg_ready), 64'(!e_busy));
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic cfg_write(input int ch, input int h, input int p, input int d, input int m);
    cfg_valid = 1'b1; cfg_ch = CH_W'(ch); cfg_half = DIV_W'(h);
    cfg_phase = DIV_W'(p); cfg_dly = DLY_W'(d); cfg_mode = 2'(m);
    tick();
    cfg_valid = 1'b0;
  endtask

  task automatic do_stop(input bit with_start);
    stop = 1'b1; start = with_start;
    tick();
    stop = 1'b0; start = 1'b0;
    tick();
  endtask

  task automatic run_episode(input int ncyc, input bit noise);
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 0; c < ncyc; c++) begin
      if (noise) begin
        start     = ($urandom_range(0, 7) == 0);
        cfg_valid = ($urandom_range(0, 3) == 0);
        cfg_ch    = CH_W'($urandom_range(0, NCH - 1));
        cfg_half  = DIV_W'($urandom_range(0, 5));
        cfg_phase = DIV_W'($urandom_range(0, 6));
        cfg_dly   = DLY_W'($urandom_range(0, 9));
        cfg_mode  = 2'($urandom_range(0, 3));
      end
      tick();
    end
    start = 1'b0; cfg_valid = 1'b0;
    do_stop(1'($urandom_range(0, 1)));
  endtask

  initial begin
    rst = 1'b1; cfg_valid = 1'b0; start = 1'b0; stop = 1'b0;
    cfg_ch = '0; cfg_half = '0; cfg_phase = '0; cfg_dly = '0; cfg_mode = '0;
    model_reset();
    #12;
    check_all();
    rst = 1'b0;

    // H=1, P=0, D=0, both edges: toggles every cycle, delayed strobe every cycle
    cfg_write(0, 1, 0, 0, 3);
    run_episode(8, 0);

    // Two channels H=4 with phase 0 and 2
    cfg_write(0, 4, 0, 0, 3);
    cfg_write(1, 4, 2, 0, 1);
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 0; c < 12; c++) tick();
    check("ecnt0_c13", 64'(edge_cnt[CNT_W-1:0]), 64'd4);
    do_stop(0);

    // Delayed strobe on pos edges: D=3 no overrun, D=5 overrun
    cfg_write(0, 1, 0, 0, 0);
    cfg_write(1, 1, 0, 0, 0);
    cfg_write(2, 2, 0, 3, 1);
    run_episode(12, 0);
    check("ovf2_d3", 64'(dly_ovf[2]), 64'd0);
    cfg_write(2, 2, 0, 5, 1);
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 0; c < 4; c++) tick();
    check("ovf2_c5", 64'(dly_ovf[2]), 64'd1);
    for (int c = 0; c < 8; c++) tick();
    do_stop(0);

    // start and stop together: nothing launches, config stays writable
    start = 1'b1; stop = 1'b1;
    tick();
    start = 1'b0; stop = 1'b0;
    check("busy_ss", 64'(busy), 64'd0);
    cfg_write(3, 3, 1, 2, 2);

    // stop while gclk high
    cfg_write(0, 3, 0, 0, 3);
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    do_stop(0);

    // Randomized episodes with noise on start and config during the run
    for (int e = 0; e < 25; e++) begin
      for (int ch = 0; ch < NCH; ch++)
        cfg_write(ch, $urandom_range(0, 5), $urandom_range(0, 6), $urandom_range(0, 9),
                  $urandom_range(0, 3));
      run_episode($urandom_range(10, 50), 1);
    end

    // Asynchronous reset in the middle of a run
    for (int ch = 0; ch < NCH; ch++) cfg_write(ch, ch + 1, ch, 2, 3);
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat ($urandom_range(3, 12)) tick();
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    check_all();
    @(posedge clk);
    #1;
    check_all();
    rst = 1'b0;
    // Default config has mode 00 on every channel, so start launches nothing
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    check("busy_after_rst", 64'(busy), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
